// File: rtl/ufifo_wr_arb_if.sv
// Write-side bus of ufifo_wr_arb: two producer channels, the FIFO write port
// and the FIFO read-strobe observation, plus credit/grant status.
interface ufifo_wr_arb_if #(
    parameter int unsigned DW     = 8,
    parameter int unsigned LGFLEN = 2
);
    logic              i_a_valid;
    logic [DW-1:0]     i_a_data;
    logic              i_a_last;
    logic              o_a_ready;

    logic              i_b_valid;
    logic [DW-1:0]     i_b_data;
    logic              i_b_last;
    logic              o_b_ready;

    logic              o_wr;
    logic [DW-1:0]     o_data;
    logic              i_rd;
    logic [LGFLEN:0]   o_fill;
    logic              o_full;
    logic [1:0]        o_grant;

    // Producer/FIFO-side environment driving the arbiter
    modport master (
        output i_a_valid, i_a_data, i_a_last, i_b_valid, i_b_data, i_b_last, i_rd,
        input  o_a_ready, o_b_ready, o_wr, o_data, o_fill, o_full, o_grant
    );

    modport slave (
        input  i_a_valid, i_a_data, i_a_last, i_b_valid, i_b_data, i_b_last, i_rd,
        output o_a_ready, o_b_ready, o_wr, o_data, o_fill, o_full, o_grant
    );
endinterface

// File: rtl/ufifo_wr_arb.sv
// Packet-locked round-robin write arbiter in front of ufifo, with a credit
// counter that keeps the FIFO write port from overflowing the buffer.
module ufifo_wr_arb #(
    parameter int unsigned DW     = 8,
    parameter int unsigned LGFLEN = 2
) (
    input  logic           i_clk,
    input  logic           i_reset,
    ufifo_wr_arb_if.slave  bus
);
    localparam logic [LGFLEN:0] DEPTH = (LGFLEN+1)'(1 << LGFLEN);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t          state, state_next;
    logic            last_b;        // 1: B was served last, so A wins the next tie
    logic            last_b_next;
    logic            acc_a, acc_b, acc;
    logic            rd_eff;
    logic [LGFLEN:0] fill_next;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            last_b <= 1'b1;
        end else begin
            state  <= state_next;
            last_b <= last_b_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next  = state;
        last_b_next = last_b;
        unique case (state)
            IDLE: begin
                if (bus.i_a_valid && bus.i_b_valid)
                    state_next = last_b ? OWN_A : OWN_B;
                else if (bus.i_a_valid)
                    state_next = OWN_A;
                else if (bus.i_b_valid)
                    state_next = OWN_B;
            end
            OWN_A: begin
                if (acc_a && bus.i_a_last) begin
                    state_next  = IDLE;
                    last_b_next = 1'b0;
                end
            end
            OWN_B: begin
                if (acc_b && bus.i_b_last) begin
                    state_next  = IDLE;
                    last_b_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.o_grant   = {state == OWN_B, state == OWN_A};
        bus.o_a_ready = (state == OWN_A) && !bus.o_full;
        bus.o_b_ready = (state == OWN_B) && !bus.o_full;
    end

    always_comb begin
        acc_a  = bus.o_a_ready && bus.i_a_valid;
        acc_b  = bus.o_b_ready && bus.i_b_valid;
        acc    = acc_a || acc_b;
        rd_eff = bus.i_rd && (bus.o_fill != '0);
        unique case ({acc, rd_eff})
            2'b10:   fill_next = bus.o_fill + 1'b1;
            2'b01:   fill_next = bus.o_fill - 1'b1;
            default: fill_next = bus.o_fill;
        endcase
    end

    // Full asserts on the edge that reaches DEPTH but releases one edge after
    // the pop, so ready never reappears in the same cycle the count drops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bus.o_wr   <= 1'b0;
            bus.o_data <= '0;
            bus.o_fill <= '0;
            bus.o_full <= 1'b0;
        end else begin
            bus.o_wr   <= acc;
            if (acc)
                bus.o_data <= acc_a ? bus.i_a_data : bus.i_b_data;
            bus.o_fill <= fill_next;
            bus.o_full <= (fill_next == DEPTH) || (bus.o_fill == DEPTH);
        end
    end
endmodule

// File: tb/tb_ufifo_wr_arb.sv
// Directed table-driven bench for ufifo_wr_arb (DW=8, LGFLEN=2, DEPTH=4).
module tb_ufifo_wr_arb;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ufifo_wr_arb_if #(.DW(8), .LGFLEN(2)) bus ();

    ufifo_wr_arb #(.DW(8), .LGFLEN(2)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       av;
        logic [7:0] ad;
        logic       al;
        logic       bv;
        logic [7:0] bd;
        logic       bl;
        logic       rd;
        logic [1:0] grant;
        logic       wr;
        logic [7:0] data;
        logic [2:0] fill;
        logic       full;
        logic       ar;
        logic       br;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [7:0] ad, input logic al,
                         input logic bv, input logic [7:0] bd, input logic bl, input logic rd);
        rst           = r;
        bus.i_a_valid = av;
        bus.i_a_data  = ad;
        bus.i_a_last  = al;
        bus.i_b_valid = bv;
        bus.i_b_data  = bd;
        bus.i_b_last  = bl;
        bus.i_rd      = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        //          rst av ad     al bv bd     bl rd  grant  wr data   fill  full ar  br
        vecs[0]  = '{1'b1,1'b1,8'h10,1'b0,1'b1,8'h20,1'b0,1'b0, 2'b00,1'b0,8'h00,3'd0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b1,8'h10,1'b0,1'b1,8'h20,1'b0,1'b0, 2'b00,1'b0,8'h00,3'd0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b1,8'h10,1'b0,1'b1,8'h20,1'b0,1'b0, 2'b01,1'b0,8'h00,3'd0,1'b0,1'b1,1'b0};
        vecs[3]  = '{1'b0,1'b1,8'h10,1'b0,1'b1,8'h20,1'b0,1'b0, 2'b01,1'b1,8'h10,3'd1,1'b0,1'b1,1'b0};
        vecs[4]  = '{1'b0,1'b1,8'h11,1'b1,1'b1,8'h20,1'b0,1'b0, 2'b00,1'b1,8'h11,3'd2,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b1,8'h10,1'b0,1'b1,8'h20,1'b0,1'b0, 2'b10,1'b0,8'h11,3'd2,1'b0,1'b0,1'b1};
        vecs[6]  = '{1'b0,1'b1,8'h10,1'b0,1'b1,8'h20,1'b0,1'b0, 2'b10,1'b1,8'h20,3'd3,1'b0,1'b0,1'b1};
        vecs[7]  = '{1'b0,1'b1,8'h10,1'b0,1'b1,8'h21,1'b1,1'b0, 2'b00,1'b1,8'h21,3'd4,1'b1,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b1,8'h10,1'b0,1'b1,8'h20,1'b0,1'b0, 2'b01,1'b0,8'h21,3'd4,1'b1,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b1,8'h10,1'b0,1'b1,8'h20,1'b0,1'b0, 2'b01,1'b0,8'h21,3'd4,1'b1,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b1,8'h10,1'b0,1'b1,8'h20,1'b0,1'b1, 2'b01,1'b0,8'h21,3'd3,1'b1,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b1,8'h10,1'b0,1'b1,8'h20,1'b0,1'b0, 2'b01,1'b0,8'h21,3'd3,1'b0,1'b1,1'b0};
        vecs[12] = '{1'b0,1'b1,8'h10,1'b0,1'b1,8'h20,1'b0,1'b0, 2'b01,1'b1,8'h10,3'd4,1'b1,1'b0,1'b0};
        vecs[13] = '{1'b0,1'b1,8'h10,1'b0,1'b1,8'h20,1'b0,1'b0, 2'b01,1'b0,8'h10,3'd4,1'b1,1'b0,1'b0};

        @(negedge clk);
        for (int unsigned i = 0; i < 14; i++) begin
            drive(vecs[i].rst, vecs[i].av, vecs[i].ad, vecs[i].al,
                  vecs[i].bv, vecs[i].bd, vecs[i].bl, vecs[i].rd);
            step();
            check($sformatf("v%0d grant", i), int'(bus.o_grant),   int'(vecs[i].grant));
            check($sformatf("v%0d wr", i),    int'(bus.o_wr),      int'(vecs[i].wr));
            check($sformatf("v%0d data", i),  int'(bus.o_data),    int'(vecs[i].data));
            check($sformatf("v%0d fill", i),  int'(bus.o_fill),    int'(vecs[i].fill));
            check($sformatf("v%0d full", i),  int'(bus.o_full),    int'(vecs[i].full));
            check($sformatf("v%0d a_ready", i), int'(bus.o_a_ready), int'(vecs[i].ar));
            check($sformatf("v%0d b_ready", i), int'(bus.o_b_ready), int'(vecs[i].br));
        end

        // Simultaneous write and pop at fill 2, then stray pop at fill 0
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check("sim reset fill", int'(bus.o_fill), 0);
        drive(1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check("sim grant", int'(bus.o_grant), 1);
        step();
        check("sim fill1", int'(bus.o_fill), 1);
        bus.i_a_data = 8'h31;
        step();
        check("sim fill2", int'(bus.o_fill), 2);
        bus.i_a_data = 8'h32;
        bus.i_a_last = 1'b1;
        bus.i_rd     = 1'b1;
        step();
        check("sim wr+rd fill", int'(bus.o_fill), 2);
        check("sim wr+rd data", int'(bus.o_data), 8'h32);
        check("sim wr+rd wr", int'(bus.o_wr), 1);
        check("sim wr+rd idle", int'(bus.o_grant), 0);
        bus.i_a_valid = 1'b0;
        bus.i_a_last  = 1'b0;
        step();
        check("sim pop fill1", int'(bus.o_fill), 1);
        step();
        check("sim pop fill0", int'(bus.o_fill), 0);
        step();
        check("sim stray rd fill", int'(bus.o_fill), 0);
        check("sim stray rd full", int'(bus.o_full), 0);
        bus.i_rd = 1'b0;

        // Ownership lock while A stalls mid-packet, then reset abandons the packet
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b0);
        step();
        check("lock grant", int'(bus.o_grant), 1);
        step();
        check("lock beat data", int'(bus.o_data), 8'hA0);
        check("lock beat fill", int'(bus.o_fill), 1);
        bus.i_a_valid = 1'b0;
        for (int unsigned c = 0; c < 3; c++) begin
            step();
            check($sformatf("lock hold%0d grant", c), int'(bus.o_grant), 1);
            check($sformatf("lock hold%0d b_ready", c), int'(bus.o_b_ready), 0);
            check($sformatf("lock hold%0d wr", c), int'(bus.o_wr), 0);
        end
        drive(1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b0);
        step();
        check("lock reset grant", int'(bus.o_grant), 0);
        check("lock reset fill", int'(bus.o_fill), 0);
        check("lock reset wr", int'(bus.o_wr), 0);
        rst = 1'b0;
        step();
        check("lock tie after reset", int'(bus.o_grant), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
